// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side word packer.
//   WORD_BYTES   - bytes per packed output word (fixed at 4)
//   TIMEOUT_DEF  - default idle cycles before a partial word is flushed
//   MAX_INFLIGHT - most read requests that may be outstanding at once
//   state_e      - packer FSM encoding (FILL, EMIT)
//   KEEP_TABLE   - byte-keep mask indexed by the number of bytes held
package fifo_pkg;

  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned TIMEOUT_DEF  = 16;
  localparam int unsigned MAX_INFLIGHT = 2;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Entry n has the low n bits set; entry 0 is never emitted but keeps the table total.
  localparam logic [4:0][3:0] KEEP_TABLE = {4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bundle of the FIFO read port and the packed-word output stream.
//   FIFO side  : empty, ren, rdata, rvalid
//   Control    : flush
//   Out stream : out_data, out_keep, out_valid, out_ready, words_sent
//   Optional   : out_parity when PACKER_PARITY_EN is defined
// Modport master is the packer's view; slave is the view of the FIFO plus downstream sink.
interface fifo_word_packer_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             empty;
  logic             ren;
  logic [7:0]       rdata;
  logic             rvalid;
  logic             flush;
  logic [31:0]      out_data;
  logic [3:0]       out_keep;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] words_sent;
`ifdef PACKER_PARITY_EN
  logic [3:0]       out_parity;
`endif

  modport master (
    input  empty, rdata, rvalid, flush, out_ready,
`ifdef PACKER_PARITY_EN
    output out_parity,
`endif
    output ren, out_data, out_keep, out_valid, words_sent
  );

  modport slave (
    output empty, rdata, rvalid, flush, out_ready,
`ifdef PACKER_PARITY_EN
    input  out_parity,
`endif
    input  ren, out_data, out_keep, out_valid, words_sent
  );

endinterface

// File: rtl/fifo_word_packer_idle_timer.sv
// pack_idle_timer: counts idle cycles while a partial word waits and raises timeout
// once TIMEOUT cycles have elapsed. timeout stays high until clear so a flush that is
// blocked by a busy output is not lost.
//   r_clk   - read-domain clock
//   rst     - asynchronous active-high reset
//   enable  - count this cycle
//   clear   - restart from zero (byte received or word emitted)
//   timeout - idle limit reached
module pack_idle_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic r_clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic timeout
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable && (cnt_q != 8'(TIMEOUT))) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign timeout = (cnt_q == 8'(TIMEOUT));

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains bytes from the async FIFO read port and packs them
// little-endian into 32-bit words with a contiguous byte-keep mask. Partial words go
// out on an idle timeout or a flush request. Everything runs on r_clk.
//   r_clk, rst        - read clock, asynchronous active-high reset
//   bus.empty/ren     - FIFO flag and registered read request
//   bus.rdata/rvalid  - read data, valid one cycle after an accepted request
//   bus.flush         - emit the current partial word
//   bus.out_*         - valid/ready word stream; words_sent counts accepted words
// Build option PACKER_PARITY_EN adds bus.out_parity (even parity per lane, 0 if unused).
module fifo_word_packer #(
  parameter int unsigned WORD_BYTES = fifo_pkg::WORD_BYTES,
  parameter int unsigned TIMEOUT    = fifo_pkg::TIMEOUT_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input logic                r_clk,
  input logic                rst,
  fifo_word_packer_if.master bus
);

  import fifo_pkg::*;

  state_e           state_q, state_d;
  logic [31:0]      pack_q, pack_d;
  logic [2:0]       byte_cnt_q, byte_cnt_d;
  logic [1:0]       inflight_q, inflight_d;
  logic             ren_q, ren_d;
  logic             flush_pend_q, flush_pend_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [3:0]       out_keep_q, out_keep_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] words_sent_q, words_sent_d;
`ifdef PACKER_PARITY_EN
  logic [3:0]       out_parity_q, out_parity_d;
`endif

  logic       accepted, out_fire, out_free, fire, timeout, idle_en, do_emit;
  logic [3:0] committed;

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .r_clk   (r_clk),
    .rst     (rst),
    .enable  (idle_en),
    .clear   (bus.rvalid | do_emit),
    .timeout (timeout)
  );

  assign idle_en = (state_q == FILL) & (byte_cnt_q != 3'd0) & (inflight_q == 2'd0) & ~bus.rvalid;

  always_comb begin
    accepted     = ren_q & ~bus.empty;
    out_fire     = out_valid_q & bus.out_ready;
    out_free     = ~out_valid_q | bus.out_ready;
    state_d      = state_q;
    pack_d       = pack_q;
    byte_cnt_d   = byte_cnt_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;
    words_sent_d = words_sent_q;
    do_emit      = 1'b0;
`ifdef PACKER_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    inflight_d   = inflight_q + {1'b0, accepted} - {1'b0, bus.rvalid};
    // A flush seen while bytes are still in flight stays pending until they land.
    flush_pend_d = flush_pend_q | (bus.flush & (byte_cnt_q != 3'd0));
    fire         = (flush_pend_d | timeout) & (byte_cnt_q != 3'd0) & (inflight_q == 2'd0);

    if (out_fire) begin
      out_valid_d  = 1'b0;
      words_sent_d = words_sent_q + 1'b1;
    end

    unique case (state_q)
      FILL: begin
        if (bus.rvalid) begin
          pack_d[{byte_cnt_q[1:0], 3'b000} +: 8] = bus.rdata;
          byte_cnt_d = byte_cnt_q + 3'd1;
        end
        if (((byte_cnt_d == 3'(WORD_BYTES)) | fire) & out_free) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        // Output register is known free here: entry into EMIT required it.
        do_emit      = 1'b1;
        out_valid_d  = 1'b1;
        out_keep_d   = KEEP_TABLE[byte_cnt_q];
        flush_pend_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
          out_data_d[8*i +: 8] = out_keep_d[i] ? pack_q[8*i +: 8] : 8'h00;
`ifdef PACKER_PARITY_EN
          out_parity_d[i] = out_keep_d[i] & (^pack_q[8*i +: 8]);
`endif
        end
        // A byte landing now starts the next word in lane 0.
        if (bus.rvalid) begin
          pack_d[7:0] = bus.rdata;
        end
        byte_cnt_d = {2'b00, bus.rvalid};
        state_d    = FILL;
      end
      default: state_d = FILL;
    endcase

    // Only request when the returning byte is guaranteed a free lane.
    committed = {1'b0, byte_cnt_d} + {2'b00, inflight_d};
    ren_d     = ~bus.empty & (committed < 4'(WORD_BYTES)) & (inflight_d < 2'(MAX_INFLIGHT));
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      pack_q       <= 32'd0;
      byte_cnt_q   <= 3'd0;
      inflight_q   <= 2'd0;
      ren_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      out_data_q   <= 32'd0;
      out_keep_q   <= 4'd0;
      out_valid_q  <= 1'b0;
      words_sent_q <= '0;
`ifdef PACKER_PARITY_EN
      out_parity_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      pack_q       <= pack_d;
      byte_cnt_q   <= byte_cnt_d;
      inflight_q   <= inflight_d;
      ren_q        <= ren_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      words_sent_q <= words_sent_d;
`ifdef PACKER_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign bus.ren        = ren_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_keep   = out_keep_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.words_sent = words_sent_q;
`ifdef PACKER_PARITY_EN
  assign bus.out_parity = out_parity_q;
`endif

endmodule
